// File: rtl/nd_link_arb2_pkg.sv
// nd_link_arb2_pkg: shared definitions for the two-input message link arbiter.
//   - default message field widths (address, data, redundancy)
//   - FSM state encodings, kept as plain 2-bit constants
//   - NS_ON / NS_OFF level constants
//   - debug view of the arbiter's internal state
//   - NS_RED_CALC: redundancy formula as a macro, so senders build the red
//     field with the same expression the arbiter may check against
// Optional feature macro used by the arbiter: NS_ARB_RED_CHECK_EN.

`ifndef NS_RED_CALC
// Redundancy of a message: (dst + dat) mod 2^W, operands zero-extended.
`define NS_RED_CALC(W, A, B) (W'(A) + W'(B))
`endif

package nd_link_arb2_pkg;

  localparam int NS_ADDRESS_SIZE = 4;
  localparam int NS_DATA_SIZE    = 8;
  localparam int NS_REDUN_SIZE   = 4;

  localparam logic NS_ON  = 1'b1;
  localparam logic NS_OFF = 1'b0;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_SND     = 2'd1;
  localparam logic [1:0] ST_SND_REL = 2'd2;
  localparam logic [1:0] ST_RCV_ACK = 2'd3;

  // Snapshot of the arbiter core: FSM state, fairness pointer, current grant.
  typedef struct packed {
    logic [1:0] state;
    logic       prio;
    logic       gnt;
  } arb_dbg_t;

endpackage

// File: rtl/nd_link_arb2_if.sv
// nd_link_if: one four-phase message link.
//   req : sender -> receiver, level request, fields stable while high
//   ack : receiver -> sender
//   dst / dat / red : message destination, data and redundancy
// Handshake: sender raises req with fields stable; receiver raises ack;
// sender drops req; receiver drops ack; sender raises no new req until it
// has seen ack low.
// Modports: master = the sending side, slave = the receiving side.

interface nd_link_if
  import nd_link_arb2_pkg::*;
#(
  parameter int ASZ = NS_ADDRESS_SIZE,
  parameter int DSZ = NS_DATA_SIZE,
  parameter int RSZ = NS_REDUN_SIZE
);
  logic           req;
  logic           ack;
  logic [ASZ-1:0] dst;
  logic [DSZ-1:0] dat;
  logic [RSZ-1:0] red;

  modport master (output req, output dst, output dat, output red, input ack);
  modport slave  (input req, input dst, input dat, input red, output ack);
endinterface

// File: rtl/nd_link_arb2_pick.sv
// nd_rr_pick2: combinational two-way round-robin pick.
//   req0, req1 : pending requests
//   prio       : input that wins when both request
//   gnt_valid  : at least one request pending
//   gnt_id     : index of the chosen input (meaningful when gnt_valid)

module nd_rr_pick2 (
  input  logic req0,
  input  logic req1,
  input  logic prio,
  output logic gnt_valid,
  output logic gnt_id
);

  assign gnt_valid = req0 | req1;
  // A lone request wins outright; a tie goes to the fairness pointer.
  assign gnt_id    = (req0 & req1) ? prio : req1;

endmodule

// File: rtl/nd_link_arb2.sv
// nd_link_arb2: two-input, one-output round-robin arbiter for message links.
// The winning message is latched, replayed on snd0 with a four-phase
// handshake, and only after the output side has fully released is the
// handshake completed back to the winner. The losing input is left pending.
//
// Ports:
//   i_clk  : clock, all logic on posedge
//   reset  : synchronous, active-high
//   rcv0   : input link 0 (slave side)
//   rcv1   : input link 1 (slave side)
//   snd0   : output link (master side), fields hold their last latched value
//   ready  : high while idle with no transfer in flight
//   dbg    : FSM state, fairness pointer and current grant
//   err    : (NS_ARB_RED_CHECK_EN only) sticky, set after the first message
//            whose red field does not match NS_RED_CALC(dst, dat)
//
// Optional feature macro: NS_ARB_RED_CHECK_EN. When defined, a granted
// message with bad redundancy is dropped (no snd0 request) and its sender
// is released straight away.

module nd_link_arb2
  import nd_link_arb2_pkg::*;
#(
  parameter int ASZ = NS_ADDRESS_SIZE,
  parameter int DSZ = NS_DATA_SIZE,
  parameter int RSZ = NS_REDUN_SIZE
)(
  input  logic      i_clk,
  input  logic      reset,
  nd_link_if.slave  rcv0,
  nd_link_if.slave  rcv1,
  nd_link_if.master snd0,
  output logic      ready,
  output arb_dbg_t  dbg
`ifdef NS_ARB_RED_CHECK_EN
  ,
  output logic      err
`endif
);

  logic [1:0]     state;
  logic           prio;
  logic           gnt;
  logic           snd_req;
  logic           ack0;
  logic           ack1;
  logic           ready_q;
  logic [ASZ-1:0] dst_q;
  logic [DSZ-1:0] dat_q;
  logic [RSZ-1:0] red_q;

  logic           pick_valid;
  logic           pick_id;
  logic [ASZ-1:0] sel_dst;
  logic [DSZ-1:0] sel_dat;
  logic [RSZ-1:0] sel_red;
  logic           gnt_req;
  logic           fwd_ok;

  nd_rr_pick2 u_pick (
    .req0      (rcv0.req),
    .req1      (rcv1.req),
    .prio      (prio),
    .gnt_valid (pick_valid),
    .gnt_id    (pick_id)
  );

  // Fields of the input about to be granted.
  always_comb begin
    sel_dst = rcv0.dst;
    sel_dat = rcv0.dat;
    sel_red = rcv0.red;
    if (pick_id) begin
      sel_dst = rcv1.dst;
      sel_dat = rcv1.dat;
      sel_red = rcv1.red;
    end
  end

  // Request level of the input currently holding the grant.
  assign gnt_req = gnt ? rcv1.req : rcv0.req;

`ifdef NS_ARB_RED_CHECK_EN
  logic [RSZ-1:0] red_chk;
  logic           err_q;

  assign red_chk = `NS_RED_CALC(RSZ, sel_dst, sel_dat);
  assign fwd_ok  = (red_chk == sel_red);
  assign err     = err_q;
`else
  assign fwd_ok  = NS_ON;
`endif

  always_ff @(posedge i_clk) begin
    if (reset) begin
      state   <= ST_IDLE;
      prio    <= 1'b0;
      gnt     <= 1'b0;
      snd_req <= 1'b0;
      ack0    <= 1'b0;
      ack1    <= 1'b0;
      ready_q <= 1'b1;
      dst_q   <= '0;
      dat_q   <= '0;
      red_q   <= '0;
`ifdef NS_ARB_RED_CHECK_EN
      err_q   <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          // snd0.ack is deliberately not looked at here: an ack with no
          // request outstanding is a peer fault and must not move the FSM.
          if (pick_valid) begin
            gnt     <= pick_id;
            ready_q <= 1'b0;
            if (fwd_ok) begin
              dst_q   <= sel_dst;
              dat_q   <= sel_dat;
              red_q   <= sel_red;
              snd_req <= 1'b1;
              state   <= ST_SND;
            end else begin
              // Dropped message: skip the output side entirely and release
              // the sender; the output fields keep the last good message.
              ack0  <= ~pick_id;
              ack1  <= pick_id;
              state <= ST_RCV_ACK;
`ifdef NS_ARB_RED_CHECK_EN
              err_q <= 1'b1;
`endif
            end
          end
        end
        ST_SND: begin
          if (snd0.ack) begin
            snd_req <= 1'b0;
            state   <= ST_SND_REL;
          end
        end
        ST_SND_REL: begin
          // The winner is only acked once the output link is fully idle.
          if (!snd0.ack) begin
            ack0  <= ~gnt;
            ack1  <= gnt;
            state <= ST_RCV_ACK;
          end
        end
        ST_RCV_ACK: begin
          if (!gnt_req) begin
            ack0    <= 1'b0;
            ack1    <= 1'b0;
            prio    <= ~gnt;
            ready_q <= 1'b1;
            state   <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign rcv0.ack  = ack0;
  assign rcv1.ack  = ack1;
  assign snd0.req  = snd_req;
  assign snd0.dst  = dst_q;
  assign snd0.dat  = dat_q;
  assign snd0.red  = red_q;
  assign ready     = ready_q;

  assign dbg.state = state;
  assign dbg.prio  = prio;
  assign dbg.gnt   = gnt;

endmodule

// File: tb/tb_nd_link_arb2.sv
// tb_nd_link_arb2: self-checking bench for nd_link_arb2.
// Inputs are driven 1 time unit after the rising edge; outputs are read at
// the same point (after the edge) or, by the monitor, on the falling edge.
// Build with +define+NS_ARB_RED_CHECK_EN to also cover the redundancy check.

module tb_nd_link_arb2;
  import nd_link_arb2_pkg::*;

  localparam int ASZ = 4;
  localparam int DSZ = 8;
  localparam int RSZ = 4;
  localparam int TMO = 200;

  typedef struct packed {
    logic [ASZ-1:0] dst;
    logic [DSZ-1:0] dat;
    logic [RSZ-1:0] red;
  } msg_t;

  typedef struct {
    int   src;
    msg_t m;
    int   delay;
    msg_t exp_fwd;
  } vec_t;

  // ---------------- clock / reset ----------------
  logic i_clk = 1'b0;
  logic reset;
  always #5 i_clk = ~i_clk;

  logic     ready;
  arb_dbg_t dbg;
`ifdef NS_ARB_RED_CHECK_EN
  logic     err;
`endif

  nd_link_if #(.ASZ(ASZ), .DSZ(DSZ), .RSZ(RSZ)) rcv0_if ();
  nd_link_if #(.ASZ(ASZ), .DSZ(DSZ), .RSZ(RSZ)) rcv1_if ();
  nd_link_if #(.ASZ(ASZ), .DSZ(DSZ), .RSZ(RSZ)) snd_if ();

  nd_link_arb2 #(.ASZ(ASZ), .DSZ(DSZ), .RSZ(RSZ)) dut (
    .i_clk (i_clk),
    .reset (reset),
    .rcv0  (rcv0_if),
    .rcv1  (rcv1_if),
    .snd0  (snd_if),
    .ready (ready),
    .dbg   (dbg)
`ifdef NS_ARB_RED_CHECK_EN
    ,
    .err   (err)
`endif
  );

  initial begin
    repeat (50000) @(posedge i_clk);
    $display("FAIL watchdog: cycle budget exhausted");
    $fatal(1);
  end

  // ---------------- scoreboard state ----------------
  int   n_checks = 0;
  int   n_pass   = 0;
  msg_t src_q[2][$];
  msg_t cur[2];
  bit   delivered[2];
  int   last_gnt;
  msg_t got_q[$];
  logic [DSZ-1:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Message with a correct redundancy field: (dst + dat) mod 2^RSZ.
  function automatic msg_t mk(input int d, input int t);
    msg_t m;
    m.dst = ASZ'(d);
    m.dat = DSZ'(t);
    m.red = RSZ'((int'(m.dst) + int'(m.dat)) % (1 << RSZ));
    return m;
  endfunction

  function automatic msg_t snd_msg();
    msg_t m;
    m.dst = snd_if.dst;
    m.dat = snd_if.dat;
    m.red = snd_if.red;
    return m;
  endfunction

  // 0: snd0 req, 1: rcv0 ack, 2: rcv1 ack
  function automatic logic sig(input int code);
    case (code)
      0:       return snd_if.req;
      1:       return rcv0_if.ack;
      default: return rcv1_if.ack;
    endcase
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic drive_rcv(input int s, input logic r, input msg_t m);
    if (s == 0) begin
      rcv0_if.req = r; rcv0_if.dst = m.dst; rcv0_if.dat = m.dat; rcv0_if.red = m.red;
    end else begin
      rcv1_if.req = r; rcv1_if.dst = m.dst; rcv1_if.dat = m.dat; rcv1_if.red = m.red;
    end
  endtask

  task automatic wait_sig(input int code, input logic val, input string name);
    int i = 0;
    while (sig(code) !== val && i < TMO) begin
      tick();
      i++;
    end
    if (i >= TMO) check({name, "_timeout"}, 32'(sig(code)), 32'(val));
  endtask

  task automatic do_reset();
    drive_rcv(0, 1'b0, '0);
    drive_rcv(1, 1'b0, '0);
    snd_if.ack = 1'b0;
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    last_gnt = 1;
    delivered[0] = 1'b0;
    delivered[1] = 1'b0;
  endtask

  // One message through an otherwise idle arbiter, output acked after v.delay cycles.
  task automatic run_vec(input vec_t v);
    bit stable = 1'b1;
    bit early  = 1'b0;
    bit oth    = 1'b0;
    int i;
    drive_rcv(v.src, 1'b1, v.m);
    tick();
    check("vec_req_latency", 32'(snd_if.req), 32'd1);
    check("vec_fields", 32'(snd_msg()), 32'(v.exp_fwd));
    check("vec_ready_busy", 32'(ready), 32'd0);
    for (i = 0; i < v.delay; i++) begin
      tick();
      if (snd_if.req !== 1'b1 || snd_msg() !== v.exp_fwd) stable = 1'b0;
      if (rcv0_if.ack | rcv1_if.ack) early = 1'b1;
    end
    snd_if.ack = 1'b1;
    i = 0;
    while (snd_if.req !== 1'b0 && i < TMO) begin
      tick();
      i++;
      if (rcv0_if.ack | rcv1_if.ack) early = 1'b1;
    end
    check("vec_req_drop", 32'(snd_if.req), 32'd0);
    tick();
    if (rcv0_if.ack | rcv1_if.ack) early = 1'b1;
    snd_if.ack = 1'b0;
    i = 0;
    while (sig(1 + v.src) !== 1'b1 && i < TMO) begin
      tick();
      i++;
      if (sig(2 - v.src)) oth = 1'b1;
    end
    check("vec_ack_winner", 32'(sig(1 + v.src)), 32'd1);
    check("vec_ack_loser", 32'(oth | sig(2 - v.src)), 32'd0);
    check("vec_slow_stable", 32'(stable), 32'd1);
    check("vec_no_early_ack", 32'(early), 32'd0);
    drive_rcv(v.src, 1'b0, v.m);
    wait_sig(1 + v.src, 1'b0, "vec_ack_fall");
    check("vec_ready_idle", 32'(ready), 32'd1);
    check("vec_fields_hold", 32'(snd_msg()), 32'(v.exp_fwd));
  endtask

  // Sender agent: four-phase handshake for n queued messages, random gaps.
  task automatic sender(input int s, input int n, input int maxgap);
    msg_t m;
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, maxgap)) tick();
      m = src_q[s].pop_front();
      cur[s] = m;
      drive_rcv(s, 1'b1, m);
      wait_sig(1 + s, 1'b1, "agent_ack_rise");
      check("ack_after_forward", 32'(delivered[s]), 32'd1);
      delivered[s] = 1'b0;
      drive_rcv(s, 1'b0, m);
      wait_sig(1 + s, 1'b0, "agent_ack_fall");
    end
  endtask

  // Output-side receiver: acks each request after a random delay.
  task automatic responder(input int n, input int maxd);
    for (int i = 0; i < n; i++) begin
      wait_sig(0, 1'b1, "out_req_rise");
      repeat ($urandom_range(0, maxd)) tick();
      snd_if.ack = 1'b1;
      wait_sig(0, 1'b0, "out_req_fall");
      repeat ($urandom_range(0, maxd)) tick();
      snd_if.ack = 1'b0;
    end
  endtask

  // Reference model: on every new output request, the winner is whichever
  // input was requesting at the decision edge; on a tie, the input not
  // served last. The forwarded fields must be that input's message.
  task automatic monitor(input int n);
    logic pr0 = 1'b0;
    logic pr1 = 1'b0;
    logic psr = 1'b0;
    int   cnt = 0;
    int   cyc = 0;
    int   w;
    while (cnt < n && cyc < n * TMO) begin
      @(negedge i_clk);
      cyc++;
      if (snd_if.req && !psr) begin
        if (pr0 && pr1) w = 1 - last_gnt;
        else if (pr1)   w = 1;
        else            w = 0;
        check("model_forward", 32'(snd_msg()), 32'(cur[w]));
        check("model_ready_busy", 32'(ready), 32'd0);
        delivered[w] = 1'b1;
        last_gnt = w;
        got_q.push_back(snd_msg());
        cnt++;
      end
      pr0 = rcv0_if.req;
      pr1 = rcv1_if.req;
      psr = snd_if.req;
    end
    if (cnt < n) check("model_count", 32'(cnt), 32'(n));
  endtask

  // ---------------- test sequence ----------------
  initial begin
    vec_t vecs[4];
    msg_t m;
    msg_t g;
    int   nr;

    rcv0_if.req = 1'b0; rcv0_if.dst = '0; rcv0_if.dat = '0; rcv0_if.red = '0;
    rcv1_if.req = 1'b0; rcv1_if.dst = '0; rcv1_if.dat = '0; rcv1_if.red = '0;
    snd_if.ack  = 1'b0;
    reset       = 1'b1;
    last_gnt    = 1;
    delivered[0] = 1'b0;
    delivered[1] = 1'b0;
    tick();

    // Reset held 3 cycles with both inputs requesting.
    drive_rcv(0, 1'b1, mk(2, 8'h11));
    drive_rcv(1, 1'b1, mk(7, 8'h22));
    reset = 1'b1;
    repeat (3) tick();
    check("rst_rcv0_ack", 32'(rcv0_if.ack), 32'd0);
    check("rst_rcv1_ack", 32'(rcv1_if.ack), 32'd0);
    check("rst_snd_req", 32'(snd_if.req), 32'd0);
    check("rst_fields", 32'(snd_msg()), 32'd0);
    check("rst_ready", 32'(ready), 32'd1);
    check("rst_state", 32'(dbg.state), 32'd0);
    reset = 1'b0;
    tick();
    check("rst_first_grant_req", 32'(snd_if.req), 32'd1);
    check("rst_first_grant_in0", 32'(snd_msg()), 32'(mk(2, 8'h11)));
    do_reset();

    // Output ack while idle is ignored.
    snd_if.ack = 1'b1;
    repeat (3) tick();
    check("idle_ack_state", 32'(dbg.state), 32'd0);
    check("idle_ack_req", 32'(snd_if.req), 32'd0);
    check("idle_ack_ready", 32'(ready), 32'd1);
    snd_if.ack = 1'b0;
    tick();

    // Table of single-message transfers.
    vecs[0] = '{src: 1, m: mk(5, 8'h0A),  delay: 2,  exp_fwd: mk(5, 8'h0A)};
    vecs[1] = '{src: 0, m: mk(15, 8'h00), delay: 20, exp_fwd: mk(15, 8'h00)};
    vecs[2] = '{src: 1, m: mk(0, 8'hFF),  delay: 0,  exp_fwd: mk(0, 8'hFF)};
    vecs[3] = '{src: 0, m: mk(3, 8'h55),  delay: 5,  exp_fwd: mk(3, 8'h55)};
    for (int i = 0; i < 4; i++) run_vec(vecs[i]);

    // Reset while in ST_SND_REL aborts the transfer.
    do_reset();
    drive_rcv(0, 1'b1, mk(9, 8'h3C));
    tick();
    snd_if.ack = 1'b1;
    tick();
    check("abort_in_snd_rel", 32'(dbg.state), 32'(2));
    reset = 1'b1;
    snd_if.ack = 1'b0;
    drive_rcv(0, 1'b0, mk(9, 8'h3C));
    tick();
    check("abort_state", 32'(dbg.state), 32'd0);
    check("abort_acks", 32'({rcv0_if.ack, rcv1_if.ack, snd_if.req}), 32'd0);
    check("abort_ready", 32'(ready), 32'd1);
    reset = 1'b0;
    repeat (3) tick();
    check("abort_no_replay", 32'({rcv0_if.ack, snd_if.req}), 32'd0);

    // Contention: both inputs stream 4 messages each.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      src_q[0].push_back(mk(i, 1 + i));
      src_q[1].push_back(mk(8 + i, 9 + i));
      exp_q.push_back(DSZ'(1 + i));
      exp_q.push_back(DSZ'(9 + i));
    end
    got_q.delete();
    fork
      sender(0, 4, 0);
      sender(1, 4, 0);
      responder(8, 2);
      monitor(8);
    join
    check("contention_count", 32'(got_q.size()), 32'd8);
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      g = got_q.pop_front();
      check("contention_order", 32'(g.dat), 32'(exp_q.pop_front()));
    end
    exp_q.delete();

    // Randomized traffic against the reference model.
    do_reset();
    nr = 25;
    for (int i = 0; i < nr; i++) begin
      src_q[0].push_back(mk($urandom_range(0, 15), $urandom_range(0, 255)));
      src_q[1].push_back(mk($urandom_range(0, 15), $urandom_range(0, 255)));
    end
    got_q.delete();
    fork
      sender(0, nr, 3);
      sender(1, nr, 3);
      responder(2 * nr, 3);
      monitor(2 * nr);
    join
    check("random_count", 32'(got_q.size()), 32'(2 * nr));
    tick();
    check("random_end_ready", 32'(ready), 32'd1);

`ifdef NS_ARB_RED_CHECK_EN
    // Bad redundancy: dropped, sender released, err sticky.
    do_reset();
    check("err_reset", 32'(err), 32'd0);
    m.dst = 4'd3; m.dat = 8'd4; m.red = 4'd6;
    drive_rcv(0, 1'b1, m);
    tick();
    check("bad_no_snd_req", 32'(snd_if.req), 32'd0);
    check("bad_sender_acked", 32'(rcv0_if.ack), 32'd1);
    check("bad_err_set", 32'(err), 32'd1);
    drive_rcv(0, 1'b0, m);
    wait_sig(1, 1'b0, "bad_ack_fall");
    check("bad_ready", 32'(ready), 32'd1);
    m.red = 4'd7;
    vecs[0] = '{src: 0, m: m, delay: 1, exp_fwd: m};
    run_vec(vecs[0]);
    check("err_sticky", 32'(err), 32'd1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/nd_link_arb2.md
Name: nd_link_arb2

Overview:
- Two-input, one-output round-robin arbiter for message links.
- Merges two sender channels (e.g. two io_fifo sources) onto one link into a single nd_fifo receive channel.
- Latches the winning message, replays it on the output with a four-phase req/ack handshake, then completes the handshake back to the winner.
- Sequential core: 4-state FSM plus a fairness pointer.

Parameters:
ASZ, `NS_ADDRESS_SIZE, width of message destination address
DSZ, `NS_DATA_SIZE, width of message data
RSZ, `NS_REDUN_SIZE, width of redundancy field

Ports:
i_clk  input  1  single clock, all logic on posedge
reset  input  1  synchronous, active-high
rcv0_req  input  1  input 0 request (level)
rcv0_ack  output  1  input 0 acknowledge
rcv0_dst  input  ASZ  input 0 destination
rcv0_dat  input  DSZ  input 0 data
rcv0_red  input  RSZ  input 0 redundancy
rcv1_req, rcv1_ack, rcv1_dst, rcv1_dat, rcv1_red  same as input 0, for input 1
snd0_req  output  1  output request
snd0_ack  input  1  output acknowledge
snd0_dst  output  ASZ  latched destination
snd0_dat  output  DSZ  latched data
snd0_red  output  RSZ  latched redundancy
ready  output  1  high in ST_IDLE, no transfer in flight

Behaviour:
- Handshake, all links four-phase:
  - sender raises req with fields stable
  - receiver raises ack
  - sender drops req
  - receiver drops ack
  - no new req until ack is low.
- Reset (synchronous, wins over everything):
  - state=ST_IDLE, prio=0
  - rcv0_ack=rcv1_ack=snd0_req=0
  - snd0_dst/dat/red=0, ready=1.
- Reset mid-transfer aborts it. Peers must also be reset; no partial replay afterwards.
- ST_IDLE:
  - If exactly one rcvN_req is high, grant N.
  - If both are high, grant prio.
  - On grant: latch dst/dat/red into the snd0 registers, set gnt=N, snd0_req<=1, ready<=0, go ST_SND.
  - Latency: req sampled in cycle k gives snd0_req high in cycle k+1.
- ST_SND: wait snd0_ack=1, then snd0_req<=0, go ST_SND_REL.
- ST_SND_REL: wait snd0_ack=0, then rcv[gnt]_ack<=1, go ST_RCV_ACK.
- ST_RCV_ACK:
  - Wait rcv[gnt]_req=0.
  - Then rcv[gnt]_ack<=0, prio<=~gnt, ready<=1, go ST_IDLE.
- The loser's req stays pending, untouched. Its ack stays 0 throughout.
- Fairness: with both inputs continuously requesting, grants alternate 0,1,0,1.
- Output fields hold their latched value until the next grant; they are not cleared between messages.
- A request already high in the cycle the FSM returns to ST_IDLE is granted the next cycle. There is no idle bubble beyond that one ST_IDLE cycle.
- snd0_ack high while in ST_IDLE is ignored. It is a protocol violation and causes no state change.

Optional Feature:
- Macro: NS_ARB_RED_CHECK_EN.
- When defined:
  - At grant, compute chk = (dst + dat) mod 2^RSZ, zero-extended.
  - If chk != red, the message is dropped: no snd0_req. Go directly to ST_RCV_ACK, raising rcv[gnt]_ack so the sender is released.
  - Extra output port err (1 bit), sticky high from the cycle after the first bad message until reset.
- When undefined: no check, no err port, every granted message is forwarded.

Decomposition:
- Shared package/header (hglobal.v):
  - state encodings ST_IDLE=2'd0, ST_SND=2'd1, ST_SND_REL=2'd2, ST_RCV_ACK=2'd3
  - NS_ON/NS_OFF
  - the redundancy function as a macro, so senders use the same formula.
- Optional sub-module nd_rr_pick2: combinational grant = f(req0, req1, prio). Everything else stays in nd_link_arb2.

Test Plan:
- Reset: hold reset 3 cycles with both reqs high -> all acks/snd0_req 0, ready=1; first grant is input 0 (prio=0).
- Single input: rcv1 sends dst=5, dat=4'hA -> snd0_req rises next cycle with dst=5, dat=A. Bench acks after 2 cycles -> rcv1_ack rises after snd0_ack falls; rcv0_ack never rises.
- Contention: both inputs stream 4 messages each (input0 dat 1..4, input1 dat 9..C) -> output order 1,9,2,A,3,B,4,C.
- Slow output: snd0_ack delayed 20 cycles -> snd0_req and fields stable for all 20 cycles; no input acked early.
- Reset mid-transfer in ST_SND_REL -> next cycle state idle, all handshake outputs 0, no ack to the granted sender.
- With NS_ARB_RED_CHECK_EN: message dst=3, dat=4, red=6 (expected 7) -> no snd0_req, sender acked, err=1 and stays 1. Next good message (red=7) forwarded.
